// File: rtl/regfile_sb_if.sv
// Register-file bus: writeback, issue, two read ports and the Ready flag.
// Signal names are kept identical to the original regfile_sb port list.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueRegister;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Busy1;
  logic              Busy2;
  logic              Ready;

  modport master (
    output RegWrite, WriteRegister, WriteData, IssueValid, IssueRegister,
           ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, Busy1, Busy2, Ready
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, IssueValid, IssueRegister,
           ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, Busy1, Busy2, Ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard busy bits and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_run;
  logic              w_wr_ok;
  logic              w_iss_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_zero1;
  logic              w_zero2;

  assign w_run    = (r_state == RUN) && !RESET;
  assign w_wr_ok  = bus.RegWrite &&
                    !((ZERO_REG != 0) && (bus.WriteRegister == '0));
  assign w_iss_ok = bus.IssueValid &&
                    !((ZERO_REG != 0) && (bus.IssueRegister == '0));
  assign w_zero1  = (ZERO_REG != 0) && (bus.ReadRegister1 == '0);
  assign w_zero2  = (ZERO_REG != 0) && (bus.ReadRegister2 == '0);

  // Single write port shared by the clear sweep and normal writeback.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!RESET) begin
      if (r_state == CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_cnt[ADDR_W-1:0];
      end else if (w_wr_ok) begin
        w_we    = 1'b1;
        w_waddr = bus.WriteRegister;
        w_wdata = bus.WriteData;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_busy[r_cnt[ADDR_W-1:0]] <= 1'b0;
          r_cnt                     <= r_cnt + 1'b1;
          if (r_cnt == (ADDR_W+1)'(DEPTH-1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          // Issue is applied after writeback so it wins on a same-register collision.
          if (w_wr_ok) begin
            r_busy[bus.WriteRegister] <= 1'b0;
          end
          if (w_iss_ok) begin
            r_busy[bus.IssueRegister] <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.ReadData1 = '0;
    bus.Busy1     = 1'b0;
    if (w_run && !w_zero1) begin
      bus.ReadData1 = r_mem[bus.ReadRegister1];
      bus.Busy1     = r_busy[bus.ReadRegister1];
`ifdef REGFILE_BYPASS_EN
      if (bus.RegWrite && (bus.WriteRegister == bus.ReadRegister1)) begin
        bus.ReadData1 = bus.WriteData;
        bus.Busy1     = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    bus.ReadData2 = '0;
    bus.Busy2     = 1'b0;
    if (w_run && !w_zero2) begin
      bus.ReadData2 = r_mem[bus.ReadRegister2];
      bus.Busy2     = r_busy[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
      if (bus.RegWrite && (bus.WriteRegister == bus.ReadRegister2)) begin
        bus.ReadData2 = bus.WriteData;
        bus.Busy2     = 1'b0;
      end
`endif
    end
  end

  assign bus.Ready = r_ready && !RESET;
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, width of each register.
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, 1 makes register 0 hardwired to zero.
REQ-004 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 Port RESET  input  1  synchronous, active-high reset.
REQ-006 Port RegWrite  input  1  writeback enable.
REQ-007 Port WriteRegister  input  ADDR_W  writeback address.
REQ-008 Port WriteData  input  DATA_W  writeback data.
REQ-009 Port IssueValid  input  1  marks IssueRegister as pending-write (busy).
REQ-010 Port IssueRegister  input  ADDR_W  destination register of issued instruction.
REQ-011 Port ReadRegister1, ReadRegister2  input  ADDR_W  read addresses.
REQ-012 Port ReadData1, ReadData2  output  DATA_W  read data, combinational from addresses.
REQ-013 Port Busy1, Busy2  output  1  scoreboard busy bit of ReadRegister1/ReadRegister2.
REQ-014 Port Ready  output  1  high once post-reset clear sequence is complete.

Function
REQ-015 FSM states: CLEAR, RUN; RESET forces CLEAR with clear counter = 0.
REQ-016 In CLEAR with RESET low: each cycle writes 0 to reg[counter], sets busy[counter]=0, increments counter.
REQ-017 CLEAR -> RUN on the edge that clears reg[DEPTH-1]; Ready rises exactly DEPTH cycles after first cycle with RESET low.
REQ-018 In CLEAR: ReadData1/2 = 0, Busy1/2 = 0, RegWrite and IssueValid ignored.
REQ-019 In RUN: RegWrite=1 writes WriteData to reg[WriteRegister] at next edge and clears busy[WriteRegister].
REQ-020 In RUN: IssueValid=1 sets busy[IssueRegister] at next edge.
REQ-021 Same-cycle issue and writeback to same register: data written, busy stays set (issue wins).
REQ-022 ZERO_REG=1: writes and issues to register 0 dropped; ReadData of address 0 = 0; busy[0] always 0.
REQ-023 ZERO_REG=0: register 0 behaves as any other register.
REQ-024 Both read ports independent; same address on both ports returns identical data and busy.
REQ-025 Busy1/Busy2 reflect registered busy bits only (no same-cycle issue forwarding).
REQ-026 Counter width ADDR_W+1; no wrap into RUN before all DEPTH entries cleared.

Reset
REQ-027 RESET high at any time, including mid-CLEAR, restarts CLEAR at counter 0 next edge.
REQ-028 While RESET high: Ready = 0, ReadData1/2 = 0, Busy1/2 = 0.
REQ-029 Register contents not defined by RESET alone; zeroed only by CLEAR sequence.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: in RUN, RegWrite=1 with WriteRegister equal to a read address (non-zero when ZERO_REG=1) forwards WriteData to that ReadData and forces its Busy to 0 in the same cycle.
REQ-031 Macro REGFILE_BYPASS_EN undefined: reads return stored value; written data visible from cycle after write.

Verification
REQ-032 RESET 1 for 2 cycles, then 0 -> Ready=0 for 32 cycles, Ready=1 at cycle 32; reads of all 32 addresses = 0.
REQ-033 RUN, write reg1=32'h11111111, reg2=32'h22222222, reg0=32'h12345678 -> next cycle ReadData1(addr1)=11111111, ReadData2(addr2)=22222222, addr0 reads 00000000.
REQ-034 Issue reg3, then 2 cycles later write reg3=32'h33333333 -> Busy(addr3)=1 for 2 cycles, 0 after writeback edge.
REQ-035 Same cycle IssueValid and RegWrite to reg5 with 32'hA5A5A5A5 -> next cycle reg5 reads A5A5A5A5, Busy=1.
REQ-036 With REGFILE_BYPASS_EN, write reg7=32'hDEADBEEF while ReadRegister1=7 -> ReadData1=DEADBEEF same cycle; without macro -> old value same cycle, DEADBEEF next cycle.
REQ-037 RESET pulsed 1 cycle at clear counter 10 -> Ready rises 32 cycles after RESET falls; write during CLEAR has no effect.
